mmio_timer_bank: RTL and testbench



---
 rtl/mmio_timer_bank.sv | 193 +++++++++++++++++++
 tb/tb_mmio_timer_bank.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer_bank.sv
// Memory-mapped timer bank: prescaled free-running mtime plus N_TIMERS
// compare channels (one-shot or periodic), each driving one IRQ line.
// Read data is registered and returned one cycle after the access.
module mmio_timer_bank #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_6000,
  parameter int unsigned N_TIMERS   = 4,
  parameter int unsigned CNT_WIDTH  = 64,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [3:0]          write,
  input  logic [31:0]         address,
  input  logic [31:0]         data_in,
  output logic [31:0]         data_out,
  output logic [N_TIMERS-1:0] irq,
  output logic                tick
);

  localparam int unsigned WIN_BYTES = 16 + 16 * N_TIMERS;
  localparam logic [31:0] WIN_END   = BASE_ADDR + 32'(WIN_BYTES);
  // Word index inside the window; 8 channels need at most 36 words.
  localparam int unsigned IDX_W     = 6;

  // Architectural state
  logic [CNT_WIDTH-1:0]  r_mtime;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_pre_cnt;
  logic [CNT_WIDTH-1:0]  r_cmp    [N_TIMERS];
  logic [31:0]           r_reload [N_TIMERS];
  logic [2:0]            r_ctrl   [N_TIMERS];
  logic [N_TIMERS-1:0]   r_status;
  logic [31:0]           r_data_out;
  logic [N_TIMERS-1:0]   r_irq;
  logic                  r_tick;

  // Decode and next-state wires
  logic                  w_hit;
  logic                  w_wr;
  logic                  w_rd;
  logic [IDX_W-1:0]      w_word;
  logic [31:0]           w_be_mask;
  logic                  w_sel_mlo;
  logic                  w_sel_mhi;
  logic                  w_sel_pre;
  logic                  w_sel_stat;
  logic                  w_incr;
  logic [63:0]           w_mt64;
  logic [CNT_WIDTH-1:0]  w_mtime_nxt;
  logic [PRESCALE_W-1:0] w_prescale_nxt;
  logic [PRESCALE_W-1:0] w_pre_cnt_nxt;
  logic [N_TIMERS-1:0]   w_match;
  logic [63:0]           w_cmp64;
  logic [2:0]            w_ctrl_tmp;
  logic [CNT_WIDTH-1:0]  w_cmp_nxt    [N_TIMERS];
  logic [31:0]           w_reload_nxt [N_TIMERS];
  logic [2:0]            w_ctrl_nxt   [N_TIMERS];
  logic [N_TIMERS-1:0]   w_w1c;
  logic [N_TIMERS-1:0]   w_status_nxt;
  logic [N_TIMERS-1:0]   w_irq_nxt;
  logic [31:0]           w_rdata;
  logic [63:0]           w_mt_rd;
  logic [63:0]           w_cmp_rd;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  assign w_hit      = enable && (address >= BASE_ADDR) && (address < WIN_END);
  assign w_wr       = w_hit && (write != 4'b0000);
  assign w_rd       = w_hit && (write == 4'b0000);
  assign w_word     = IDX_W'((address - BASE_ADDR) >> 2);
  assign w_be_mask  = {{8{write[3]}}, {8{write[2]}}, {8{write[1]}}, {8{write[0]}}};
  assign w_sel_mlo  = w_wr && (w_word == IDX_W'(0));
  assign w_sel_mhi  = w_wr && (w_word == IDX_W'(1)) && (CNT_WIDTH == 64);
  assign w_sel_pre  = w_wr && (w_word == IDX_W'(2));
  assign w_sel_stat = w_wr && (w_word == IDX_W'(3));
  assign w_incr     = (r_pre_cnt == r_prescale);

  // Prescaler and mtime next value; written lanes override the increment
  always_comb begin
    w_prescale_nxt = r_prescale;
    w_pre_cnt_nxt  = w_incr ? '0 : r_pre_cnt + PRESCALE_W'(1);
    if (w_sel_pre) begin
      w_prescale_nxt = PRESCALE_W'(lane_merge(32'(r_prescale), data_in, w_be_mask));
      w_pre_cnt_nxt  = '0;
    end
    w_mt64 = 64'(r_mtime);
    if (w_incr) w_mt64 = 64'(r_mtime + CNT_WIDTH'(1));
    if (w_sel_mlo) w_mt64[31:0]  = lane_merge(w_mt64[31:0], data_in, w_be_mask);
    if (w_sel_mhi) w_mt64[63:32] = lane_merge(w_mt64[63:32], data_in, w_be_mask);
    w_mtime_nxt = CNT_WIDTH'(w_mt64);
  end

  // Channel compare, auto-reload / disarm, then bus writes win on written lanes
  always_comb begin
    w_match      = '0;
    w_cmp64      = '0;
    w_ctrl_tmp   = '0;
    w_cmp_nxt    = r_cmp;
    w_reload_nxt = r_reload;
    w_ctrl_nxt   = r_ctrl;
    for (int i = 0; i < N_TIMERS; i++) begin
      w_match[i] = r_ctrl[i][0] && (r_mtime >= r_cmp[i]);
      w_cmp64    = 64'(r_cmp[i]);
      w_ctrl_tmp = r_ctrl[i];
      if (w_match[i]) begin
        if (r_ctrl[i][1] && (r_reload[i] != 32'd0))
          w_cmp64 = 64'(r_cmp[i] + CNT_WIDTH'(r_reload[i]));
        else
          w_ctrl_tmp[0] = 1'b0;
      end
      if (w_wr && (w_word == IDX_W'(4 + 4 * i)))
        w_cmp64[31:0] = lane_merge(w_cmp64[31:0], data_in, w_be_mask);
      if (w_wr && (CNT_WIDTH == 64) && (w_word == IDX_W'(5 + 4 * i)))
        w_cmp64[63:32] = lane_merge(w_cmp64[63:32], data_in, w_be_mask);
      if (w_wr && (w_word == IDX_W'(6 + 4 * i)))
        w_reload_nxt[i] = lane_merge(r_reload[i], data_in, w_be_mask);
      if (w_wr && (w_word == IDX_W'(7 + 4 * i)))
        w_ctrl_tmp = 3'(lane_merge(32'(w_ctrl_tmp), data_in, w_be_mask));
      w_cmp_nxt[i]  = CNT_WIDTH'(w_cmp64);
      w_ctrl_nxt[i] = w_ctrl_tmp;
    end
  end

  // Status: W1C from the bus, a same-cycle match sets and wins
  assign w_w1c        = w_sel_stat ? N_TIMERS'(data_in & w_be_mask) : '0;
  assign w_status_nxt = (r_status & ~w_w1c) | w_match;

  // IRQ level from next-state status and IRQ_EN, registered below
  always_comb begin
    w_irq_nxt = '0;
    for (int i = 0; i < N_TIMERS; i++)
      w_irq_nxt[i] = w_status_nxt[i] & w_ctrl_nxt[i][2];
  end

  // Read mux over current register values
  always_comb begin
    w_rdata  = '0;
    w_mt_rd  = 64'(r_mtime);
    w_cmp_rd = '0;
    if (w_word == IDX_W'(0)) w_rdata = w_mt_rd[31:0];
    if (w_word == IDX_W'(1)) w_rdata = w_mt_rd[63:32];
    if (w_word == IDX_W'(2)) w_rdata = 32'(r_prescale);
    if (w_word == IDX_W'(3)) w_rdata = 32'(r_status);
    for (int i = 0; i < N_TIMERS; i++) begin
      w_cmp_rd = 64'(r_cmp[i]);
      if (w_word == IDX_W'(4 + 4 * i)) w_rdata = w_cmp_rd[31:0];
      if (w_word == IDX_W'(5 + 4 * i)) w_rdata = w_cmp_rd[63:32];
      if (w_word == IDX_W'(6 + 4 * i)) w_rdata = r_reload[i];
      if (w_word == IDX_W'(7 + 4 * i)) w_rdata = 32'(r_ctrl[i]);
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mtime    <= '0;
      r_prescale <= '0;
      r_pre_cnt  <= '0;
      r_status   <= '0;
      r_data_out <= '0;
      r_irq      <= '0;
      r_tick     <= 1'b0;
      for (int i = 0; i < N_TIMERS; i++) begin
        r_cmp[i]    <= '1;
        r_reload[i] <= '0;
        r_ctrl[i]   <= '0;
      end
    end else begin
      r_mtime    <= w_mtime_nxt;
      r_prescale <= w_prescale_nxt;
      r_pre_cnt  <= w_pre_cnt_nxt;
      r_status   <= w_status_nxt;
      r_data_out <= w_rd ? w_rdata : 32'd0;
      r_irq      <= w_irq_nxt;
      r_tick     <= w_incr;
      for (int i = 0; i < N_TIMERS; i++) begin
        r_cmp[i]    <= w_cmp_nxt[i];
        r_reload[i] <= w_reload_nxt[i];
        r_ctrl[i]   <= w_ctrl_nxt[i];
      end
    end
  end

  assign data_out = r_data_out;
  assign irq      = r_irq;
  assign tick     = r_tick;

endmodule

// File: tb/tb_mmio_timer_bank.sv
// Directed bench for mmio_timer_bank: a 64-bit/4-channel instance and a
// 32-bit/2-channel instance sharing clock and reset.
module tb_mmio_timer_bank;

  localparam logic [31:0] BASE   = 32'h8000_6000;
  localparam logic [31:0] MT_LO  = BASE + 32'h00;
  localparam logic [31:0] MT_HI  = BASE + 32'h04;
  localparam logic [31:0] PRESC  = BASE + 32'h08;
  localparam logic [31:0] STAT   = BASE + 32'h0C;
  localparam logic [31:0] C0_LO  = BASE + 32'h10;
  localparam logic [31:0] C0_HI  = BASE + 32'h14;
  localparam logic [31:0] C0_CTL = BASE + 32'h1C;
  localparam logic [31:0] C1_LO  = BASE + 32'h20;
  localparam logic [31:0] C1_HI  = BASE + 32'h24;
  localparam logic [31:0] C1_RLD = BASE + 32'h28;
  localparam logic [31:0] C1_CTL = BASE + 32'h2C;

  logic        clk;
  logic        reset;
  logic        enable, en2;
  logic [3:0]  write, wr2;
  logic [31:0] address, addr2;
  logic [31:0] data_in, din2;
  logic [31:0] data_out, dout2;
  logic [3:0]  irq;
  logic [1:0]  irq2;
  logic        tick, tick2;

  int n_err;
  int n_chk;

  mmio_timer_bank #(.BASE_ADDR(BASE), .N_TIMERS(4), .CNT_WIDTH(64), .PRESCALE_W(16)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .write(write), .address(address),
    .data_in(data_in), .data_out(data_out), .irq(irq), .tick(tick)
  );

  mmio_timer_bank #(.BASE_ADDR(BASE), .N_TIMERS(2), .CNT_WIDTH(32), .PRESCALE_W(16)) u_dut32 (
    .clk(clk), .reset(reset), .enable(en2), .write(wr2), .address(addr2),
    .data_in(din2), .data_out(dout2), .irq(irq2), .tick(tick2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // All bus tasks start at a negedge and return at the following negedge.
  task automatic rd(input bit u2, input logic [31:0] a, output logic [31:0] d);
    if (u2) begin en2 = 1'b1; wr2 = 4'h0; addr2 = a; end
    else begin enable = 1'b1; write = 4'h0; address = a; end
    @(negedge clk);
    d = u2 ? dout2 : data_out;
    enable = 1'b0; en2 = 1'b0;
  endtask

  task automatic wr(input bit u2, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    if (u2) begin en2 = 1'b1; wr2 = be; addr2 = a; din2 = d; end
    else begin enable = 1'b1; write = be; address = a; data_in = d; end
    @(negedge clk);
    enable = 1'b0; en2 = 1'b0; write = 4'h0; wr2 = 4'h0;
  endtask

  task automatic wait_irq(input int bitn, input int limit, output bit found);
    found = 1'b0;
    for (int k = 0; k < limit; k++) begin
      if (irq[bitn]) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [31:0] d, a0, b0, m0, v0;
  int          cnt;
  int          kwait;
  bit          found;

  initial begin
    n_err = 0; n_chk = 0;
    reset = 1'b1;
    enable = 0; write = 0; address = 0; data_in = 0;
    en2 = 0; wr2 = 0; addr2 = 0; din2 = 0;

    tbl[0]  = '{BASE + 32'h30, 32'h0000_0000, 4'h0, 32'hFFFF_FFFF};
    tbl[1]  = '{BASE + 32'h30, 32'h1234_5678, 4'hF, 32'h1234_5678};
    tbl[2]  = '{BASE + 32'h30, 32'hAABB_CCDD, 4'h5, 32'h12BB_56DD};
    tbl[3]  = '{BASE + 32'h34, 32'h0000_0000, 4'h0, 32'hFFFF_FFFF};
    tbl[4]  = '{BASE + 32'h34, 32'h0000_00A5, 4'h1, 32'hFFFF_FFA5};
    tbl[5]  = '{BASE + 32'h38, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF};
    tbl[6]  = '{BASE + 32'h3C, 32'hFFFF_FFFA, 4'hF, 32'h0000_0002};
    tbl[7]  = '{BASE + 32'h4C, 32'h0000_0004, 4'hF, 32'h0000_0004};
    tbl[8]  = '{BASE + 32'h4D, 32'h0000_0000, 4'h0, 32'h0000_0004};
    tbl[9]  = '{BASE + 32'h50, 32'h1111_1111, 4'hF, 32'h0000_0000};
    tbl[10] = '{BASE - 32'h4,  32'h2222_2222, 4'hF, 32'h0000_0000};
    tbl[11] = '{STAT,          32'h0000_0000, 4'h0, 32'h0000_0000};
    tbl[12] = '{PRESC,         32'hFFFF_1234, 4'hF, 32'h0000_1234};
    tbl[13] = '{PRESC,         32'h0000_AB00, 4'h2, 32'h0000_AB34};
    tbl[14] = '{PRESC,         32'h0000_0000, 4'hF, 32'h0000_0000};

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_data_out", data_out, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    reset = 1'b0;

    // Test 1: prescale 0, tick every cycle, mtime == elapsed edges
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tick) cnt++;
    end
    check("t1_tick_count", 32'(cnt), 32'd20);
    rd(0, MT_LO, d);
    check("t1_mtime_lo", d, 32'd20);
    @(negedge clk);
    check("t1_idle_dout_zero", data_out, 32'h0);
    rd(0, MT_HI, d);
    check("t1_mtime_hi", d, 32'h0);

    // Register table: lane writes, masking, window edges
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].be != 4'h0) wr(0, tbl[i].addr, tbl[i].wdata, tbl[i].be);
      rd(0, tbl[i].addr, d);
      check($sformatf("tbl[%0d]", i), d, tbl[i].exp);
    end

    // Test 2: prescale 3 gives one increment per 4 cycles
    wr(0, PRESC, 32'd3, 4'hF);
    rd(0, MT_LO, a0);
    cnt = 0;
    for (int k = 0; k < 39; k++) begin
      @(negedge clk);
      if (k < 36 && tick) cnt++;
    end
    rd(0, MT_LO, b0);
    check("t2_mtime_delta", b0 - a0, 32'd10);
    check("t2_tick_count", 32'(cnt), 32'd9);
    wr(0, PRESC, 32'd0, 4'hF);

    // Test 3: one-shot on channel 0
    rd(0, MT_LO, m0);
    wr(0, C0_LO, m0 + 32'd8, 4'hF);
    wr(0, C0_HI, 32'd0, 4'hF);
    wr(0, C0_CTL, 32'h5, 4'hF);
    wait_irq(0, 40, found);
    check("t3_irq0_rise", 32'(found), 32'd1);
    rd(0, MT_LO, d);
    check("t3_mtime_at_rise", d, m0 + 32'd9);
    rd(0, C0_CTL, d);
    check("t3_ctrl_en_cleared", d, 32'h4);
    rd(0, STAT, d);
    check("t3_status", d, 32'h1);
    wr(0, STAT, 32'h1, 4'hF);
    check("t3_irq0_cleared", 32'(irq), 32'h0);
    repeat (5) @(negedge clk);
    check("t3_irq0_stays_low", 32'(irq), 32'h0);

    // Test 4: periodic on channel 1 at 100/150/200
    wr(0, MT_LO, 32'd0, 4'hF);
    wr(0, C1_LO, 32'd100, 4'hF);
    wr(0, C1_HI, 32'd0, 4'hF);
    wr(0, C1_RLD, 32'd50, 4'hF);
    wr(0, C1_CTL, 32'h7, 4'hF);
    for (int h = 0; h < 3; h++) begin
      wait_irq(1, 120, found);
      check($sformatf("t4_hit%0d_irq", h), 32'(found), 32'd1);
      rd(0, MT_LO, d);
      check($sformatf("t4_hit%0d_mtime", h), d, 32'(101 + 50 * h));
      wr(0, STAT, 32'h2, 4'hF);
      check($sformatf("t4_hit%0d_w1c", h), 32'(irq[1]), 32'h0);
    end
    rd(0, C1_LO, d);
    check("t4_cmp_after_3", d, 32'd250);

    // Test 5: W1C on the exact match edge, set wins
    rd(0, MT_LO, v0);
    kwait = 250 - int'(v0);
    if (kwait < 1) kwait = 1;
    repeat (kwait - 1) @(negedge clk);
    wr(0, STAT, 32'h2, 4'hF);
    check("t5_irq1_set_wins", 32'(irq[1]), 32'h1);
    rd(0, STAT, d);
    check("t5_status_set_wins", d, 32'h2);
    rd(0, C1_LO, d);
    check("t5_cmp_reloaded", d, 32'd300);
    wr(0, C1_CTL, 32'h3, 4'hF);
    check("t5_irq_masked", 32'(irq), 32'h0);
    rd(0, STAT, d);
    check("t5_status_held", d, 32'h2);

    // Test 6: 32-bit instance wraps, HI reads zero
    wr(1, MT_LO, 32'hFFFF_FFFE, 4'hF);
    rd(1, MT_LO, d);
    check("t6_w32_fffe", d, 32'hFFFF_FFFE);
    rd(1, MT_LO, d);
    check("t6_w32_ffff", d, 32'hFFFF_FFFF);
    rd(1, MT_LO, d);
    check("t6_w32_wrap", d, 32'h0);
    wr(1, MT_HI, 32'h1234, 4'hF);
    rd(1, MT_HI, d);
    check("t6_w32_mt_hi", d, 32'h0);
    rd(1, C0_HI, d);
    check("t6_w32_cmp_hi", d, 32'h0);
    rd(1, C0_LO, d);
    check("t6_w32_cmp_lo", d, 32'hFFFF_FFFF);
    rd(1, BASE + 32'h30, d);
    check("t6_w32_out_of_window", d, 32'h0);

    // Asynchronous reset in the middle of a read
    wr(0, C1_CTL, 32'h7, 4'hF);
    check("t6_irq1_before_rst", 32'(irq), 32'h2);
    enable = 1'b1; write = 4'h0; address = MT_LO;
    en2 = 1'b1; wr2 = 4'h0; addr2 = MT_LO;
    @(negedge clk);
    check("t6_dout_nonzero", 32'(data_out != 32'h0), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("t6_async_dout", data_out, 32'h0);
    check("t6_async_dout32", dout2, 32'h0);
    check("t6_async_irq", 32'(irq), 32'h0);
    check("t6_async_tick", 32'(tick), 32'h0);
    enable = 1'b0; en2 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    rd(0, MT_LO, d);
    check("t6_mtime_after_rst", d, 32'h0);
    rd(0, C1_HI, d);
    check("t6_cmp_after_rst", d, 32'hFFFF_FFFF);
    rd(0, STAT, d);
    check("t6_status_after_rst", d, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
